btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 6: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-sample count before accepting a level change; legal range 2..2^20.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000: cycles held pressed before the first auto-repeat (used only with the Configuration macro).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between auto-repeats (used only with the Configuration macro).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port btn_raw, input, WIDTH bits: asynchronous button pins; 0 = pressed.
REQ-008 SHALL have port btn_out, output, WIDTH bits: registered debounced level; 0 = pressed; drives the button PIO in_port directly.
REQ-009 SHALL have port press_pulse, output, WIDTH bits: registered, one cycle high on every 1->0 transition of the matching btn_out bit.

Function
REQ-010 SHALL pass each bit of btn_raw through a two-flop synchronizer (sync0, then sync1) before any other logic uses it.
REQ-011 SHALL keep, per bit, a stable state bit and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-012 SHALL clear the counter of a bit whenever its sync1 equals its stable bit.
REQ-013 SHALL increment the counter of a bit while its sync1 differs from its stable bit and the count is below DEBOUNCE_CYCLES-1.
REQ-014 SHALL, when sync1 still differs from stable and the count equals DEBOUNCE_CYCLES-1, load stable from sync1 and clear the counter on the same edge.
REQ-015 SHALL change btn_out on edge DEBOUNCE_CYCLES+2, counting as edge 1 the first edge that samples the new raw level, provided the raw level is constant throughout.
REQ-016 SHALL ignore any bounce that returns to the stable value before the count completes: the counter clears and btn_out is unchanged.
REQ-017 SHALL process channels fully independently; simultaneous changes on several bits SHALL update those bits on the same edge.
REQ-018 SHALL make press_pulse[i] high for exactly one cycle, registered on the same edge that btn_out[i] falls.
REQ-019 SHALL keep press_pulse low on any rising (release) transition.
REQ-020 SHALL NOT let the counter wrap; the counter saturates by construction of REQ-013 and REQ-014.

Reset
REQ-021 SHALL, while reset_n is low and regardless of clk, drive sync0, sync1, stable and btn_out to all ones.
REQ-022 SHALL, while reset_n is low and regardless of clk, drive all counters and press_pulse to zero.
REQ-023 SHALL, on a reset in the middle of a debounce or repeat sequence, discard that sequence with no pulse emitted.
REQ-024 SHALL NOT emit a press_pulse on release of reset; buttons held across reset produce a press only after the full debounce time.

Configuration
REQ-025 SHALL compile in auto-repeat only when macro BTN_DEBOUNCE_AUTOREPEAT_EN is defined; auto-repeat uses a per-bit repeat counter.
REQ-026 SHALL, with the macro defined and a stable bit that fell at edge T and stays pressed, drive btn_out high for exactly the single cycle following edge T+REPEAT_DELAY.
REQ-027 SHALL, with the macro defined, repeat the one-cycle high every REPEAT_PERIOD cycles after the first repeat while the bit stays pressed.
REQ-028 SHALL, with the macro defined, assert press_pulse on each re-fall of btn_out.
REQ-029 SHALL, with the macro defined, clear the repeat counter on a debounced release or on reset.
REQ-030 SHALL, with the macro undefined, make btn_out identical to stable, include no repeat logic, and leave REPEAT_DELAY and REPEAT_PERIOD unused.

Verification
REQ-031 SHALL cover reset: with WIDTH=6, btn_out=6'h3F and press_pulse=6'h00 during reset and after release with btn_raw=6'h3F.
REQ-032 SHALL cover a clean press: DEBOUNCE_CYCLES=4, btn_raw[0] 1->0 and held -> btn_out[0] falls on edge 6 and press_pulse[0]=1 for that single cycle.
REQ-033 SHALL cover bounce rejection: DEBOUNCE_CYCLES=4, btn_raw[2] low for 3 cycles then high -> btn_out stays 6'h3F and press_pulse stays 0.
REQ-034 SHALL cover simultaneous presses: btn_raw 6'h3F->6'h1D on one edge -> btn_out becomes 6'h1D on a single edge, with press_pulse=6'h22 for one cycle.
REQ-035 SHALL cover release: held bit 0 returns high -> btn_out[0] rises on edge 6 and press_pulse stays 0.
REQ-036 SHALL cover auto-repeat: macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5, bit 0 fell at edge T and held -> btn_out[0] is high only in the cycles after edges T+10, T+15 and T+20, with press_pulse[0] high at T+11, T+16 and T+21.

Source files
------------

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Per-channel two-flop synchronizer and counter debouncer with
//               registered press pulses. Optional auto-repeat is compiled in
//               only when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_out,
    output logic [WIDTH-1:0] press_pulse
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW        = $clog2(RMAX + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE   = RW'(1);
`endif

    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q <= '1;
            sync1_q <= '1;
        end else begin
            sync0_q <= btn_raw;
            sync1_q <= sync0_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic          stable_q;
        logic          stable_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          out_q;
        logic          out_d;
        logic          pulse_q;
        logic          pulse_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        logic [RW-1:0] rep_q;
        logic [RW-1:0] rep_d;
        logic          first_q;
        logic          first_d;
        logic          fire;
`endif

        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            // Counter only runs while the synchronized level disagrees with
            // the accepted level; terminal count loads the new level.
            if (sync1_q[i] != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_d = sync1_q[i];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            rep_d   = '0;
            first_d = 1'b1;
            fire    = 1'b0;
            // Repeat timer runs only while held pressed across this edge;
            // the first interval is REPEAT_DELAY, later ones REPEAT_PERIOD.
            if (!stable_q && !stable_d) begin
                first_d = first_q;
                if (rep_q == (first_q ? REP_FIRST : REP_NEXT)) begin
                    fire    = 1'b1;
                    first_d = 1'b0;
                end else begin
                    rep_d = rep_q + REP_ONE;
                end
            end
            out_d = stable_d | fire;
`else
            out_d = stable_d;
`endif
            pulse_d = out_q & ~out_d;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= 1'b1;
                cnt_q    <= '0;
                out_q    <= 1'b1;
                pulse_q  <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rep_q    <= '0;
                first_q  <= 1'b1;
`endif
            end else begin
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
                out_q    <= out_d;
                pulse_q  <= pulse_d;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                rep_q    <= rep_d;
                first_q  <= first_d;
`endif
            end
        end

        assign btn_out[i]     = out_q;
        assign press_pulse[i] = pulse_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debounce
// Description : Table-driven and directed self-checking bench for btn_debounce.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce;

    localparam int W = 6;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] btn_raw = 6'h3F;
    logic [W-1:0] btn_out;
    logic [W-1:0] press_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] raw;
        logic [5:0] out;
        logic [5:0] pulse;
    } vec_t;

    vec_t vecs[$];

    btn_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_out    (btn_out),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] r, input logic [5:0] o, input logic [5:0] p);
        vec_t v;
        v.raw   = r;
        v.out   = o;
        v.pulse = p;
        vecs.push_back(v);
    endtask

    task automatic add_n(input logic [5:0] r, input int n, input logic [5:0] o);
        for (int k = 0; k < n; k++) add(r, o, 6'h00);
    endtask

    initial begin
        logic [5:0] exp_o;
        logic [5:0] exp_p;

        // Clean press of bit 0: falls on edge 6 with a single pulse.
        add_n(6'h3E, 5, 6'h3F); add(6'h3E, 6'h3E, 6'h01); add(6'h3E, 6'h3E, 6'h00);
        // Release of bit 0: rises on edge 6, no pulse.
        add_n(6'h3F, 5, 6'h3E); add(6'h3F, 6'h3F, 6'h00); add(6'h3F, 6'h3F, 6'h00);
        // Bit 2 low for only 3 cycles: rejected.
        add_n(6'h3B, 3, 6'h3F); add_n(6'h3F, 6, 6'h3F);
        // Bit 3 low for exactly 4 cycles: accepted, then released.
        add_n(6'h37, 4, 6'h3F); add(6'h3F, 6'h3F, 6'h00); add(6'h3F, 6'h37, 6'h08);
        add_n(6'h3F, 3, 6'h37); add(6'h3F, 6'h3F, 6'h00); add(6'h3F, 6'h3F, 6'h00);
        // Simultaneous press of bits 1 and 5.
        add_n(6'h1D, 5, 6'h3F); add(6'h1D, 6'h1D, 6'h22); add(6'h1D, 6'h1D, 6'h00);
        add_n(6'h3F, 5, 6'h1D); add(6'h3F, 6'h3F, 6'h00); add(6'h3F, 6'h3F, 6'h00);

        // Asynchronous reset, checked before any clock edge.
        #1 reset_n = 1'b0;
        #2;
        check("reset_async_out", btn_out, 6'h3F);
        check("reset_async_pulse", press_pulse, 6'h00);
        tick(); tick();
        check("reset_held_out", btn_out, 6'h3F);
        check("reset_held_pulse", press_pulse, 6'h00);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_reset_out", btn_out, 6'h3F);
            check("post_reset_pulse", press_pulse, 6'h00);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            btn_raw = vecs[i].raw;
            tick();
            check($sformatf("vec%0d_out", i), btn_out, vecs[i].out);
            check($sformatf("vec%0d_pulse", i), press_pulse, vecs[i].pulse);
        end

        // Long hold of bit 0: auto-repeat build re-pulses, default build holds low.
        btn_raw = 6'h3E;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("hold_pre_out", btn_out, 6'h3F);
        end
        tick();
        check("hold_fall_out", btn_out, 6'h3E);
        check("hold_fall_pulse", press_pulse, 6'h01);
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_o = {5'h1F, AR && (k == 10 || k == 15 || k == 20)};
            exp_p = {5'h00, AR && (k == 11 || k == 16 || k == 21)};
            check($sformatf("hold_T+%0d_out", k), btn_out, exp_o);
            check($sformatf("hold_T+%0d_pulse", k), press_pulse, exp_p);
        end
        btn_raw = 6'h3F;
        for (int k = 0; k < 10; k++) tick();
        check("hold_release_out", btn_out, 6'h3F);
        check("hold_release_pulse", press_pulse, 6'h00);

        // Reset while bit 1 is debounced low; held button must re-debounce.
        btn_raw = 6'h3D;
        for (int k = 0; k < 7; k++) tick();
        check("pre_midreset_out", btn_out, 6'h3D);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_out", btn_out, 6'h3F);
        check("midreset_pulse", press_pulse, 6'h00);
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rehold_wait_out", btn_out, 6'h3F);
            check("rehold_wait_pulse", press_pulse, 6'h00);
        end
        tick();
        check("rehold_fall_out", btn_out, 6'h3D);
        check("rehold_fall_pulse", press_pulse, 6'h02);
        tick();
        check("rehold_after_pulse", press_pulse, 6'h00);
        btn_raw = 6'h3F;
        for (int k = 0; k < 8; k++) tick();
        check("final_out", btn_out, 6'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
